boton_ajuste: RTL

Conditions the two raw push-button inputs used to adjust the time registers during edit mode. It synchronises, debounces, edge-detects and (optionally) auto-repeats each button, and emits single-cycle `UP`/`DOWN` strobes that drive the `UP`/`DOWN` inputs of the BCD time-field registers (minutes, hours, etc.). It sits between the board pins and the register bank, and is gated by the same `Modificando` edit-mode flag.

---
 rtl/boton_ajuste.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/boton_ajuste.sv
//==============================================================================
// Module   : boton_ajuste
// Brief    : Synchronises, debounces and edge-detects the two adjust buttons and
//            emits single-cycle UP/DOWN strobes while Modificando is high.
//            Auto-repeat is built only when BOTON_AUTOREPEAT_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module boton_ajuste #(
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN_UP,
    input  logic BTN_DOWN,
    input  logic Modificando,
    output logic UP,
    output logic DOWN
);

    localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEB_CYCLES - 1);

`ifdef BOTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RPT  = 2'd2,
        S_LOCK = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_LOCK    = 2'd3
    } state_t;

    logic w_unused_cfg;
    assign w_unused_cfg = HOLD_CYCLES[0] ^ REPEAT_CYCLES[0];
`endif

    logic [1:0] w_btn;
    logic [1:0] w_deb;
    logic [1:0] w_strobe;

    assign w_btn = {BTN_DOWN, BTN_UP};
    assign UP    = w_strobe[0];
    assign DOWN  = w_strobe[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic             r_sync1_q;
        logic             r_sync2_q;
        logic             r_deb_q;
        logic             w_deb_d;
        logic [CNT_W-1:0] r_cnt_q;
        logic [CNT_W-1:0] w_cnt_d;
        logic             r_prev_q;
        state_t           r_state_q;
        state_t           w_state_d;
        logic             r_strobe_q;
        logic             w_strobe_d;
        logic             w_other;
        logic             w_rise;
`ifdef BOTON_AUTOREPEAT_EN
        logic [CNT_W-1:0] r_timer_q;
        logic [CNT_W-1:0] w_timer_d;
`endif

        // Left out of reset so a button held across reset is re-accepted quickly.
        always_ff @(posedge CLK) begin
            r_sync1_q <= w_btn[gi];
            r_sync2_q <= r_sync1_q;
        end

        always_comb begin
            w_deb_d = r_deb_q;
            w_cnt_d = '0;
            if (r_sync2_q != r_deb_q) begin
                if (r_cnt_q == C_DEB_LAST) begin
                    w_deb_d = ~r_deb_q;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
        end

        assign w_deb[gi] = r_deb_q;
        assign w_other   = w_deb[1-gi];
        assign w_rise    = r_deb_q & ~r_prev_q;

        always_comb begin
            w_state_d  = r_state_q;
            w_strobe_d = 1'b0;
`ifdef BOTON_AUTOREPEAT_EN
            w_timer_d  = r_timer_q;
`endif
            case (r_state_q)
                S_IDLE: begin
                    if (w_rise) begin
                        if (w_other) begin
                            w_state_d = S_LOCK;
                        end else if (Modificando) begin
                            w_strobe_d = 1'b1;
`ifdef BOTON_AUTOREPEAT_EN
                            w_state_d  = S_HOLD;
                            w_timer_d  = '0;
`else
                            w_state_d  = S_PRESSED;
`endif
                        end
                    end
                end
`ifdef BOTON_AUTOREPEAT_EN
                // Release and mode exit win over a strobe due in the same cycle.
                S_HOLD, S_RPT: begin
                    w_timer_d = r_timer_q + 1'b1;
                    if (!r_deb_q || !Modificando) begin
                        w_state_d = S_IDLE;
                    end else if (w_other) begin
                        w_state_d = S_LOCK;
                    end else if (r_timer_q == ((r_state_q == S_HOLD) ? C_HOLD_LAST : C_RPT_LAST)) begin
                        w_state_d  = S_RPT;
                        w_strobe_d = 1'b1;
                        w_timer_d  = '0;
                    end
                end
`else
                S_PRESSED: begin
                    if (!r_deb_q || !Modificando) begin
                        w_state_d = S_IDLE;
                    end else if (w_other) begin
                        w_state_d = S_LOCK;
                    end
                end
`endif
                S_LOCK: begin
                    if (!r_deb_q && !w_other) begin
                        w_state_d = S_IDLE;
                    end
                end
                default: w_state_d = S_IDLE;
            endcase
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                r_deb_q    <= 1'b0;
                r_cnt_q    <= '0;
                r_prev_q   <= 1'b0;
                r_state_q  <= S_IDLE;
                r_strobe_q <= 1'b0;
`ifdef BOTON_AUTOREPEAT_EN
                r_timer_q  <= '0;
`endif
            end else begin
                r_deb_q    <= w_deb_d;
                r_cnt_q    <= w_cnt_d;
                r_prev_q   <= r_deb_q;
                r_state_q  <= w_state_d;
                r_strobe_q <= w_strobe_d;
`ifdef BOTON_AUTOREPEAT_EN
                r_timer_q  <= w_timer_d;
`endif
            end
        end

        assign w_strobe[gi] = r_strobe_q;
    end

endmodule

`default_nettype wire
